// File: rtl/sample_framer.sv
// Frames a fall-through FIFO sample stream into packets: one tagged header word
// carrying an 8-bit sequence number, followed by FRAME_LEN payload samples.
module sample_framer #(
  parameter int          DATASIZE    = 12,
  parameter int          FRAME_LEN   = 16,
  parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
  input  logic                read_clk,
  input  logic                read_reset,
  input  logic                enable,
  input  logic                read_empty,
  input  logic [DATASIZE-1:0] read_data,
  output logic                read_enable,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_first,
  output logic                out_last,
  output logic [7:0]          seq_num
);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t                state, state_next;
  logic [7:0]            count;
  logic                  slot_free;
  logic                  load_header;
  logic                  load_sample;
  logic                  frame_end;
  logic [DATASIZE-1:0]   header_word;

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    header_word                   = '0;
    header_word[DATASIZE-1 -: 4]  = SYNC_NIBBLE;
    header_word[7:0]              = seq_num;
  end

  // Pop only when the sample can be loaded on this same edge, so nothing is
  // ever held outside the output register.
  always_comb begin
    state_next  = state;
    load_header = 1'b0;
    load_sample = 1'b0;
    frame_end   = 1'b0;
    read_enable = 1'b0;
    if (!read_reset) begin
      case (state)
        IDLE: begin
          if (enable && !read_empty && slot_free) begin
            load_header = 1'b1;
            state_next  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!read_empty && slot_free) begin
            read_enable = 1'b1;
            load_sample = 1'b1;
            if (count == LAST_IDX) begin
              frame_end  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      count     <= '0;
      seq_num   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_header) begin
      out_data  <= header_word;
      out_valid <= 1'b1;
      out_first <= 1'b1;
      out_last  <= 1'b0;
    end else if (load_sample) begin
      out_data  <= read_data;
      out_valid <= 1'b1;
      out_first <= 1'b0;
      out_last  <= frame_end;
      if (frame_end) begin
        count   <= '0;
        seq_num <= seq_num + 8'd1;
      end else begin
        count   <= count + 8'd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: a queue models the fall-through FIFO and a
// scoreboard of expected {first,last,data} words is checked on every transfer.
module tb_sample_framer;

  localparam int DW = 12;
  localparam int FL = 16;

  logic          read_clk = 1'b0;
  logic          read_reset;
  logic          enable;
  logic          read_empty;
  logic [DW-1:0] read_data;
  logic          read_enable;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [7:0]    seq_num;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] fifo[$];
  int            checks   = 0;
  int            failures = 0;

  always #5 read_clk = ~read_clk;

  sample_framer #(
    .DATASIZE    (DW),
    .FRAME_LEN   (FL),
    .SYNC_NIBBLE (4'hA)
  ) dut (
    .read_clk    (read_clk),
    .read_reset  (read_reset),
    .enable      (enable),
    .read_empty  (read_empty),
    .read_data   (read_data),
    .read_enable (read_enable),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_first   (out_first),
    .out_last    (out_last),
    .seq_num     (seq_num)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void refresh();
    read_empty = (fifo.size() == 0);
    read_data  = (fifo.size() != 0) ? fifo[0] : '0;
  endfunction

  function automatic logic [DW-1:0] hdr(input int s);
    hdr = 12'hA00 | DW'(s % 256);
  endfunction

  // One clock: compare any transfer before the edge, then apply the FIFO pop.
  task automatic cycle();
    word_t obs;
    word_t e;
    logic  pop;
    refresh();
    #2;
    pop = read_enable;
    if (out_valid && out_ready) begin
      check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        obs = {out_first, out_last, out_data};
        check("xfer_word", 32'(obs), 32'(e));
      end
    end
    @(posedge read_clk);
    #1;
    if (pop) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_header(input int s);
    exp_q.push_back({1'b1, 1'b0, hdr(s)});
  endtask

  task automatic push_samples(input int n, input int start_idx, input int base,
                              input bit rnd, input bit expect_it);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom_range(0, 4095)) : DW'(base + i);
      fifo.push_back(w);
      if (expect_it) exp_q.push_back({1'b0, (start_idx + i == FL), w});
    end
  endtask

  task automatic pulse_reset();
    out_ready  = 1'b0;
    read_reset = 1'b1;
    cycle();
    read_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    read_reset = 1'b1;
    enable     = 1'b1;
    out_ready  = 1'b0;
    fifo.push_back(12'h123);
    refresh();
    cycle();
    cycle();
    #1;
    check("rst_read_enable", 32'(read_enable), 32'd0);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_first",   32'(out_first),   32'd0);
    check("rst_out_last",    32'(out_last),    32'd0);
    check("rst_out_data",    32'(out_data),    32'd0);
    check("rst_seq_num",     32'(seq_num),     32'd0);
    fifo.delete();
    read_reset = 1'b0;
    cycle();

    // Preloaded full frame at full rate
    out_ready = 1'b1;
    push_header(0);
    push_samples(16, 1, 1, 1'b0, 1'b1);
    drain(40, n);
    check("full_rate_cycles", 32'(n), 32'd18);
    check("frame1_seq_num",   32'(seq_num),   32'd1);
    check("frame1_idle",      32'(out_valid), 32'd0);

    // Header held under backpressure
    pulse_reset();
    push_header(0);
    push_samples(16, 1, 'h200, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_valid",  32'(out_valid),   32'd1);
      check("hold_data",   32'(out_data),    32'hA00);
      check("hold_first",  32'(out_first),   32'd1);
      check("hold_no_pop", 32'(read_enable), 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    drain(40, n);
    check("hold_seq_num", 32'(seq_num), 32'd1);

    // FIFO underrun mid-frame
    push_header(1);
    push_samples(8, 1, 'h300, 1'b0, 1'b1);
    drain(40, n);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("gap_valid",  32'(out_valid),   32'd0);
      check("gap_no_pop", 32'(read_enable), 32'd0);
      cycle();
    end
    push_samples(8, 9, 'h308, 1'b0, 1'b1);
    drain(40, n);
    for (int i = 0; i < 4; i++) cycle();
    check("gap_seq_num", 32'(seq_num), 32'd2);

    // Reset during payload abandons the frame
    push_header(2);
    push_samples(5, 1, 'h400, 1'b0, 1'b1);
    push_samples(11, 6, 'h405, 1'b0, 1'b0);
    drain(40, n);
    out_ready  = 1'b0;
    read_reset = 1'b1;
    refresh();
    #1;
    check("midrst_no_pop", 32'(read_enable), 32'd0);
    cycle();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_first", 32'(out_first), 32'd0);
    check("midrst_last",  32'(out_last),  32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    check("midrst_seq",   32'(seq_num),   32'd0);
    fifo.delete();
    read_reset = 1'b0;
    out_ready  = 1'b1;
    push_header(0);
    push_samples(16, 1, 'h500, 1'b0, 1'b1);
    drain(40, n);
    check("midrst_next_seq", 32'(seq_num), 32'd1);

    // enable dropped inside a frame
    push_header(1);
    push_samples(16, 1, 'h600, 1'b0, 1'b1);
    push_samples(4, 1, 'h700, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() > 13 && n < 20) begin
      cycle();
      n++;
    end
    enable = 1'b0;
    drain(40, n);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("noen_valid",  32'(out_valid),   32'd0);
      check("noen_no_pop", 32'(read_enable), 32'd0);
      cycle();
    end
    check("noen_seq_num", 32'(seq_num), 32'd2);
    fifo.delete();
    enable = 1'b1;

    // Sequence number wrap across 257 frames
    pulse_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      if (f == 256) check("wrap_seq_before_257", 32'(seq_num), 32'd0);
      push_header(f);
      push_samples(16, 1, 0, 1'b1, 1'b1);
      drain(40, n);
    end
    check("wrap_seq_after", 32'(seq_num), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
